// File: rtl/ahb_pkg.sv
// Shared AHB encodings (transfer type, burst type, slave FSM state) and
// helpers that classify a transfer as legal for a given data-bus width.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } trans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } burst_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR1   = 2'd2,
    ST_ERR2   = 2'd3
  } state_e;

  // True when a transfer of 2**size bytes fits on the data bus.
  function automatic logic size_fits(input logic [2:0] size, input int unsigned data_width);
    return ((32'd8 << size) <= data_width);
  endfunction

  // True when the low address bits are aligned to 2**size bytes.
  function automatic logic addr_aligned(input logic [2:0] addr_lo, input logic [2:0] size);
    logic [7:0] mask;
    mask = (8'd1 << size) - 8'd1;
    return (({5'd0, addr_lo} & mask) == 8'd0);
  endfunction

endpackage

// File: rtl/ahb_strb_gen.sv
// Byte-lane strobe generator: ones for the lanes covered by a write of
// 2**size bytes starting at the address' lane offset, zeros for reads.
module ahb_strb_gen
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]              addr_i,
  input  logic [2:0]              size_i,
  input  logic                    write_i,
  output logic [DATA_WIDTH/8-1:0] strb_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  int unsigned lo_c;
  int unsigned nb_c;

  always_comb begin
    lo_c   = 32'(addr_i) % STRB_W;
    nb_c   = 32'd1 << size_i;
    strb_o = '0;
    for (int b = 0; b < STRB_W; b++) begin
      strb_o[b] = write_i && (32'(b) >= lo_c) && (32'(b) < (lo_c + nb_c));
    end
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB slave front end bridging one AHB data phase to a simple backend request.
// Optional feature macro AHB_WSTRB_EN adds the registered byte-strobe output other_strb_out.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int unsigned AHB_ADDR_WIDTH = 32,
  parameter int unsigned AHB_DATA_WIDTH = 32,
  parameter int unsigned WAIT_TIMEOUT   = 16
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rst_in,
  input  logic                      ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
  input  logic [1:0]                ahb_trans_in,
  input  logic                      ahb_write_in,
  input  logic [2:0]                ahb_size_in,
  input  logic [2:0]                ahb_burst_in,
  input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
  input  logic                      ahb_ready_in,
  output logic                      ahb_readyout_out,
  output logic                      ahb_resp_out,
  output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
  output logic [AHB_ADDR_WIDTH-1:0] other_addr_out,
  output logic                      other_write_out,
  output logic [2:0]                other_size_out,
  output logic                      other_valid_out,
  output logic [AHB_DATA_WIDTH-1:0] other_wdata_out,
`ifdef AHB_WSTRB_EN
  output logic [AHB_DATA_WIDTH/8-1:0] other_strb_out,
`endif
  input  logic                      other_ready_in,
  input  logic                      other_error_in,
  input  logic [AHB_DATA_WIDTH-1:0] other_rdata_in
);

  localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);

  state_e                    state_q;
  state_e                    launch_c;
  logic [CNT_W-1:0]          cnt_q;
  logic [CNT_W-1:0]          cnt_d;
  logic [AHB_ADDR_WIDTH-1:0] addr_q;
  logic                      write_q;
  logic [2:0]                size_q;
  logic                      accept_c;
  logic                      bad_c;
  logic                      done_c;
  logic                      sample_c;
  logic                      start_c;
  logic                      in_access_c;
  logic                      unused_burst;

  // Burst type is carried on the bus but has no effect on a single-slot slave.
  assign unused_burst = ^ahb_burst_in;

  assign accept_c = ahb_sel_in & ahb_ready_in &
                    ((ahb_trans_in == TRANS_NONSEQ) | (ahb_trans_in == TRANS_SEQ));
  assign bad_c    = ~size_fits(ahb_size_in, AHB_DATA_WIDTH) |
                    ~addr_aligned(ahb_addr_in[2:0], ahb_size_in);
  assign done_c   = other_ready_in & ~other_error_in;
  // An address phase is only taken while the previous data phase is finishing.
  assign sample_c = (state_q == ST_IDLE) | (state_q == ST_ERR2) |
                    ((state_q == ST_ACCESS) & done_c);
  assign start_c  = accept_c & sample_c;
  assign launch_c = start_c ? (bad_c ? ST_ERR1 : ST_ACCESS) : ST_IDLE;
  assign cnt_d    = cnt_q + CNT_W'(1);

  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERR2: begin
          state_q <= launch_c;
          cnt_q   <= '0;
        end
        ST_ACCESS: begin
          if (other_error_in) begin
            state_q <= ST_ERR1;
          end else if (other_ready_in) begin
            state_q <= launch_c;
            cnt_q   <= '0;
          end else if (cnt_d == CNT_W'(WAIT_TIMEOUT)) begin
            state_q <= ST_ERR1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_ERR1: state_q <= ST_ERR2;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else if (start_c) begin
      addr_q  <= ahb_addr_in;
      write_q <= ahb_write_in;
      size_q  <= ahb_size_in;
    end
  end

`ifdef AHB_WSTRB_EN
  logic [AHB_DATA_WIDTH/8-1:0] strb_c;
  logic [AHB_DATA_WIDTH/8-1:0] strb_q;

  ahb_strb_gen #(
    .DATA_WIDTH(AHB_DATA_WIDTH)
  ) u_strb_gen (
    .addr_i (ahb_addr_in[2:0]),
    .size_i (ahb_size_in),
    .write_i(ahb_write_in),
    .strb_o (strb_c)
  );

  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      strb_q <= '0;
    end else if (start_c) begin
      strb_q <= strb_c;
    end
  end

  assign other_strb_out = strb_q;
`endif

  // Reset forces the idle bus response even before the first clock edge.
  assign in_access_c = ~ahb_rst_in & (state_q == ST_ACCESS);

  always_comb begin
    ahb_readyout_out = 1'b1;
    if (!ahb_rst_in) begin
      case (state_q)
        ST_ACCESS: ahb_readyout_out = done_c;
        ST_ERR1:   ahb_readyout_out = 1'b0;
        default:   ahb_readyout_out = 1'b1;
      endcase
    end
  end

  assign ahb_resp_out    = ~ahb_rst_in & ((state_q == ST_ERR1) | (state_q == ST_ERR2));
  assign ahb_rdata_out   = (in_access_c & ~write_q) ? other_rdata_in : '0;
  assign other_valid_out = in_access_c;
  assign other_addr_out  = addr_q;
  assign other_write_out = write_q;
  assign other_size_out  = size_q;
  assign other_wdata_out = ahb_wdata_in;

endmodule
